sequence_detector_prog: RTL and testbench
=========================================

SEQUENCE_DETECTOR_PROG -- requirements
Module: sequence_detector_prog

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter COUNT_W, default 8, match counter width.
REQ-003 SHALL have parameter DEFAULT_PATTERN, width MAX_LEN, default 'h06, pattern loaded at reset.
REQ-004 SHALL have parameter DEFAULT_LEN, default 4, pattern length loaded at reset.
REQ-005 SHALL have parameter DEFAULT_OVERLAP, default 0, overlap mode loaded at reset (0 = non-overlapping).
REQ-006 SHALL have one clock, clk, with a synchronous, active-high reset, reset.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 en  input  1  bit-valid strobe; data_in is consumed only on edges with en=1.
REQ-010 data_in  input  1  serial data bit.
REQ-011 cfg_load  input  1  single-cycle pulse that latches pattern_in, len_in and overlap_in.
REQ-012 pattern_in  input  MAX_LEN  pattern; bit len-1 = first bit received, bit 0 = last bit received.
REQ-013 len_in  input  $clog2(MAX_LEN+1)  pattern length.
REQ-014 overlap_in  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-015 count_clr  input  1  clears match_count.
REQ-016 detected  output  1  registered, one-cycle match pulse.
REQ-017 match_count  output  COUNT_W  saturating count of matches.
REQ-018 cfg_err  output  1  registered, one-cycle pulse when a cfg_load is rejected.

Function
REQ-019 SHALL keep a history shift register hist[MAX_LEN-1:0] and a fill counter fill (0..MAX_LEN); on an en edge, hist <= {hist[MAX_LEN-2:0], data_in} and fill increments, saturating at MAX_LEN.
REQ-020 A match SHALL occur on an en edge when the updated hist equals the active pattern in bits [len-1:0] and the updated fill >= len; bits at and above len are ignored.
REQ-021 detected SHALL be high for exactly the one cycle following the clock edge that samples the final pattern bit; it SHALL be 0 in every other cycle, including cycles with en=0.
REQ-022 On a match in non-overlapping mode, fill SHALL be reset to 0, so the next match needs len new bits; in overlapping mode fill SHALL be left unchanged.
REQ-023 On each match, match_count SHALL increment by 1 and saturate at 2^COUNT_W-1 with no wrap-around.
REQ-024 count_clr SHALL set match_count to 0 on the next edge; if count_clr and a match occur on the same edge, count_clr wins (count = 0), and detected still pulses.
REQ-025 A cfg_load with 2 <= len_in <= MAX_LEN SHALL latch the new configuration on that edge and clear hist, fill and detected; match_count SHALL be unaffected.
REQ-026 A cfg_load with len_in < 2 or len_in > MAX_LEN SHALL leave the configuration, hist and fill unchanged and pulse cfg_err for one cycle.
REQ-027 If cfg_load and en occur on the same edge, cfg_load SHALL take priority and that data bit is discarded, whether or not the load is rejected.
REQ-028 With en=0, hist, fill and match_count SHALL hold, except for count_clr and cfg_load actions.

Reset
REQ-029 On reset, the block SHALL load pattern = DEFAULT_PATTERN, len = DEFAULT_LEN and overlap = DEFAULT_OVERLAP.
REQ-030 On reset, hist, fill, match_count, detected and cfg_err SHALL be 0.
REQ-031 reset SHALL take priority over cfg_load, count_clr and en in the same cycle.
REQ-032 A reset asserted mid-sequence SHALL discard the partial sequence: the bits after reset need a full len-bit pattern to match.

Verification
REQ-033 After reset with defaults, send 0,1,1,0 with en=1 -> detected pulses one cycle after the 4th bit edge; match_count = 1.
REQ-034 Defaults, send 0,1,1,0,1,1,0 -> one detection only (after bit 4); repeat with cfg_load overlap_in=1, len_in=4, pattern_in='h06 -> detections after bits 4 and 7.
REQ-035 Load pattern 'b101, len 3, overlap 1, then send 1,0,1,0,1 -> detections after bits 3 and 5; with overlap 0 -> detection after bit 3 only.
REQ-036 Apply cfg_load with len_in = 0, then with len_in = MAX_LEN+1 -> cfg_err pulses once for each; the default 0110 detection still works afterwards.
REQ-037 Set COUNT_W = 2 and produce 5 matches -> match_count saturates at 3; count_clr on the same edge as the 6th match -> match_count = 0 and detected = 1.
REQ-038 Send 0,1,1, then reset for 1 cycle, then 0 -> no detection; send 0,1,1,0 with en=0 gaps between bits -> exactly one detection.

Source files
------------

// File: rtl/sequence_detector_prog.sv
// +--------------------------------------------------------------------------+
// | sequence_detector_prog: runtime-programmable serial pattern detector.    |
// | Revision 1.0 - initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sequence_detector_prog #(
  parameter int                 MAX_LEN         = 8,
  parameter int                 COUNT_W         = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 'h06,
  parameter int                 DEFAULT_LEN     = 4,
  parameter int                 DEFAULT_OVERLAP = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           data_in,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             pattern_in,
  input  logic [$clog2(MAX_LEN+1)-1:0]   len_in,
  input  logic                           overlap_in,
  input  logic                           count_clr,
  output logic                           detected,
  output logic [COUNT_W-1:0]             match_count,
  output logic                           cfg_err
);

  localparam int                 LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]   C_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   C_MIN_LEN = LEN_W'(2);
  localparam logic [LEN_W-1:0]   C_DEF_LEN = LEN_W'(DEFAULT_LEN);
  localparam logic [COUNT_W-1:0] C_CNT_MAX = {COUNT_W{1'b1}};

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  // The oldest history bit shifts out before it is ever compared, so only
  // MAX_LEN-1 bits are stored; the full window is rebuilt with data_in.
  logic [MAX_LEN-2:0] hist_q;
  logic [LEN_W-1:0]   fill_q;

  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] len_mask;
  logic               cfg_ok;
  logic               match;
  logic               match_fire;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign hist_next  = {hist_q, data_in};
  assign fill_next  = (fill_q == C_MAX_LEN) ? fill_q : fill_q + LEN_W'(1);
  assign cfg_ok     = (len_in >= C_MIN_LEN) && (len_in <= C_MAX_LEN);
  assign match      = (((hist_next ^ pattern_q) & len_mask) == '0) && (fill_next >= len_q);
  assign match_fire = en && !cfg_load && match;

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q   <= DEFAULT_PATTERN;
      len_q       <= C_DEF_LEN;
      overlap_q   <= (DEFAULT_OVERLAP != 0);
      hist_q      <= '0;
      fill_q      <= '0;
      match_count <= '0;
      detected    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      detected <= 1'b0;
      cfg_err  <= 1'b0;

      // A load (accepted or not) consumes the edge; any en bit is dropped.
      if (cfg_load) begin
        if (cfg_ok) begin
          pattern_q <= pattern_in;
          len_q     <= len_in;
          overlap_q <= overlap_in;
          hist_q    <= '0;
          fill_q    <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (en) begin
        hist_q <= hist_next[MAX_LEN-2:0];
        if (match) begin
          detected <= 1'b1;
          fill_q   <= overlap_q ? fill_next : '0;
        end else begin
          fill_q   <= fill_next;
        end
      end

      if (count_clr) begin
        match_count <= '0;
      end else if (match_fire && (match_count != C_CNT_MAX)) begin
        match_count <= match_count + COUNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sequence_detector_prog.sv
// +--------------------------------------------------------------------------+
// | tb_sequence_detector_prog: directed self-checking bench.                 |
// | Revision 1.0 - initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sequence_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic               data_in;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern_in;
  logic [LEN_W-1:0]   len_in;
  logic               overlap_in;
  logic               count_clr;

  logic               detected;
  logic [7:0]         match_count;
  logic               cfg_err;
  logic               detected2;
  logic [1:0]         match_count2;
  logic               cfg_err2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sequence_detector_prog #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in),
    .cfg_load(cfg_load), .pattern_in(pattern_in), .len_in(len_in),
    .overlap_in(overlap_in), .count_clr(count_clr),
    .detected(detected), .match_count(match_count), .cfg_err(cfg_err)
  );

  sequence_detector_prog #(.MAX_LEN(MAX_LEN), .COUNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in),
    .cfg_load(cfg_load), .pattern_in(pattern_in), .len_in(len_in),
    .overlap_in(overlap_in), .count_clr(count_clr),
    .detected(detected2), .match_count(match_count2), .cfg_err(cfg_err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                         input logic ov, input logic en_v, input logic d);
    cfg_load   = 1'b1;
    pattern_in = pat;
    len_in     = len;
    overlap_in = ov;
    en         = en_v;
    data_in    = d;
    tick();
    cfg_load = 1'b0;
    en       = 1'b0;
  endtask

  // bits/exp are written first-bit-first (MSB of the n-bit field goes first).
  task automatic send_bits(input string tag, input logic [15:0] bits, input int n,
                           input logic [15:0] exp, input bit gaps);
    for (int i = 0; i < n; i++) begin
      en      = 1'b1;
      data_in = bits[n-1-i];
      tick();
      en = 1'b0;
      check($sformatf("%s_det[%0d]", tag, i + 1), 32'(detected), 32'(exp[n-1-i]));
      if (gaps) begin
        tick();
        tick();
        check($sformatf("%s_gap[%0d]", tag, i + 1), 32'(detected), 32'd0);
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    en         = 1'b0;
    data_in    = 1'b0;
    cfg_load   = 1'b0;
    pattern_in = '0;
    len_in     = '0;
    overlap_in = 1'b0;
    count_clr  = 1'b0;
    tick();
    do_reset();
    check("rst_det", 32'(detected), 32'd0);
    check("rst_cnt", 32'(match_count), 32'd0);
    check("rst_cnt2", 32'(match_count2), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);

    // Default 0110, non-overlapping.
    send_bits("def", 16'b0110, 4, 16'b0001, 1'b0);
    check("def_cnt", 32'(match_count), 32'd1);
    tick();
    check("def_idle", 32'(detected), 32'd0);

    send_bits("nov", 16'b0110110, 7, 16'b0001000, 1'b0);
    check("nov_cnt", 32'(match_count), 32'd2);

    do_load(8'h06, 4'd4, 1'b1, 1'b0, 1'b0);
    check("ld_err", 32'(cfg_err), 32'd0);
    check("ld_cnt", 32'(match_count), 32'd2);
    send_bits("ovl", 16'b0110110, 7, 16'b0001001, 1'b0);
    check("ovl_cnt", 32'(match_count), 32'd4);
    check("sat_cnt2", 32'(match_count2), 32'd3);

    // 101 overlapping; count_clr lands on the 6th match.
    do_load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
    send_bits("p101o", 16'b101, 3, 16'b001, 1'b0);
    check("p101o_cnt", 32'(match_count), 32'd5);
    check("p101o_cnt2", 32'(match_count2), 32'd3);
    en = 1'b1; data_in = 1'b0;
    tick();
    check("p101o_det4", 32'(detected), 32'd0);
    data_in = 1'b1; count_clr = 1'b1;
    tick();
    en = 1'b0; count_clr = 1'b0;
    check("clr_det", 32'(detected), 32'd1);
    check("clr_cnt", 32'(match_count), 32'd0);
    check("clr_cnt2", 32'(match_count2), 32'd0);

    do_load(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
    send_bits("p101n", 16'b10101, 5, 16'b00100, 1'b0);
    check("p101n_cnt", 32'(match_count), 32'd1);

    // Reset restores defaults; illegal lengths are rejected.
    do_reset();
    check("rst2_cnt", 32'(match_count), 32'd0);
    do_load(8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
    check("bad0_err", 32'(cfg_err), 32'd1);
    tick();
    check("bad0_err_end", 32'(cfg_err), 32'd0);
    do_load(8'hFF, 4'(MAX_LEN + 1), 1'b1, 1'b0, 1'b0);
    check("bad9_err", 32'(cfg_err), 32'd1);
    check("bad9_err2", 32'(cfg_err2), 32'd1);
    send_bits("after_bad", 16'b0110, 4, 16'b0001, 1'b0);
    check("after_bad_cnt", 32'(match_count), 32'd1);

    // Mid-sequence reset discards the partial pattern.
    send_bits("pre_rst", 16'b011, 3, 16'b000, 1'b0);
    do_reset();
    send_bits("post_rst", 16'b0, 1, 16'b0, 1'b0);
    check("post_rst_cnt", 32'(match_count), 32'd0);
    send_bits("gaps", 16'b0110, 4, 16'b0001, 1'b1);
    check("gaps_cnt", 32'(match_count), 32'd1);

    // Load on the same edge as en wins; the data bit is dropped.
    send_bits("pri_a", 16'b011, 3, 16'b000, 1'b0);
    do_load(8'h06, 4'd4, 1'b0, 1'b1, 1'b0);
    check("pri_ok_det", 32'(detected), 32'd0);
    check("pri_ok_err", 32'(cfg_err), 32'd0);
    send_bits("pri_b", 16'b011, 3, 16'b000, 1'b0);
    do_load(8'h06, 4'd1, 1'b0, 1'b1, 1'b0);
    check("pri_bad_det", 32'(detected), 32'd0);
    check("pri_bad_err", 32'(cfg_err), 32'd1);
    send_bits("pri_c", 16'b0, 1, 16'b1, 1'b0);
    check("pri_cnt", 32'(match_count), 32'd2);
    check("pri_cnt2", 32'(match_count2), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
